cmult_arbiter: RTL
==================

// Module: cmult_arbiter
// PURPOSE
//  Shares one complex multiplier (compl_mult) between N_REQ requesters in the DPD datapath,
//  e.g. basis-function generators and coefficient appliers. Each requester supplies an operand
//  pair over valid/ready. A round-robin arbiter grants one pair per cycle into a 2-stage
//  pipeline. The product returns on a shared response bus, tagged with the requester index.
// PARAMETERS
//  W      20  width of each I/Q component; complex words are {I,Q}, 2*W bits, Q1.(W-1)
//  N_REQ  4   number of requesters, 2..16
// PORTS
//  clk        in   1           system clock, rising edge
//  reset_b    in   1           asynchronous reset, active low
//  cfg_mask   in   N_REQ       1 = requester enabled; a masked requester is never granted
//  req_valid  in   N_REQ       per-requester operand valid
//  req_ready  out  N_REQ       per-requester accept; at most one bit set per cycle
//  req_a      in   N_REQ*2*W   operand A, requester i at [i*2W +: 2W]
//  req_b      in   N_REQ*2*W   operand B, same packing
//  rsp_valid  out  1           product valid
//  rsp_ready  in   1           downstream accept
//  rsp_id     out  ID_W        index of the requester that issued the product
//  rsp_data   out  2*W         product {I,Q}
// BEHAVIOUR
//  - Reset values: rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, all pipeline valids=0,
//    rr pointer=N_REQ-1 so requester 0 wins first.
//  - Reset asserted mid-operation: in-flight products are discarded and never returned.
//  - Eligibility: eligible[i] = req_valid[i] & cfg_mask[i].
//  - Grant: the first eligible index searching rr+1, rr+2, ... with modulo-N_REQ wrap.
//    Grant is combinational from eligible and rr.
//  - Pipeline, stage 1 (s1): registered a, b, id, valid.
//  - compl_mult is combinational on s1.
//  - Stage 2 (s2): registered product, id, valid. s2 drives rsp_*.
//  - Advance rules:
//      adv2 = ~s2_v | rsp_ready
//      adv1 = ~s1_v | adv2
//  - req_ready[i] = grant[i] & adv1. A transfer occurs when valid & ready.
//    rr <= granted index only on a transfer.
//  - Latency: transfer in cycle t gives rsp_valid in cycle t+2 when rsp_ready stays 1.
//    Throughput is 1 product per cycle.
//  - Stall: while rsp_valid & ~rsp_ready, s2 holds. s1 holds if occupied.
//    rsp_data and rsp_id stay stable until accepted.
//  - No bubbles at full occupancy: with s2 full and rsp_ready=1, s2 and s1 advance and a new
//    grant is accepted in the same cycle.
//  - Requesters must hold valid and operands until ready. Deasserting valid without ready
//    is legal: the request is withdrawn and rr is unchanged.
//  - Product arithmetic is exactly compl_mult:
//      I = ai*bi - aq*bq,  Q = aq*bi + ai*bq
//    Each sum is taken as bits [2W-2:W-1], rounded half-up by adding bit W-2.
//    Results are not saturated: (-1+j0)*(-1+j0) wraps to -1.
//  - cfg_mask changes take effect on the next grant. Already-accepted operands complete.
//  - Responses leave in acceptance order. rsp_id disambiguates requesters.
// STRUCTURE
//  - dpd_pkg holds:
//      CPLX_W = 20
//      localparam ID_W = (N_REQ>1) ? $clog2(N_REQ) : 1
//      cplx_t packed struct {I,Q}
//      the rr_next function (masked round-robin search)
//  - One sub-module is natural: rr_arbiter (eligible, rr, transfer -> grant, rr_q).
//  - compl_mult is instantiated once, unmodified.
//  - Expected RTL size: about 180 lines.
// TESTING
//  Values below use W=20, so 0.5 = 0x40000.
//  1. Single request, rsp_ready=1:
//     req0 a=b={0x40000,0} -> cycle t+2: rsp_valid=1, rsp_id=0, rsp_data={0x20000,0}.
//  2. Negative real result:
//     a=b={0,0x40000} -> rsp_data={0xE0000,0}, i.e. -0.25 real.
//  3. All 4 requesters valid continuously, mask=0xF -> grants 0,1,2,3,0,...
//     One response per cycle; rsp_id follows the same sequence.
//  4. Backpressure: rsp_ready=0 for 5 cycles with all valid ->
//     rsp_valid held with stable data and id; req_ready=0 after s1 fills.
//     On release there is no lost or duplicated product.
//  5. cfg_mask=0b0101, all valid -> only ids 0 and 2, alternating.
//  6. Reset pulse with 2 products in flight -> rsp_valid=0 at once.
//     After release, requester 0 is granted first and no stale response appears.

Source files
------------

// File: rtl/dpd_pkg.sv
// Shared types and helpers for the DPD datapath: complex word layout,
// requester-id sizing and the masked round-robin search.
package dpd_pkg;

    localparam int CPLX_W = 20;

    typedef struct packed {
        logic signed [CPLX_W-1:0] i;
        logic signed [CPLX_W-1:0] q;
    } cplx_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of eligible searching rr+1, rr+2, ... modulo n; -1 when none.
    function automatic int rr_next(input logic [15:0] eligible, input int rr, input int n);
        int sel;
        int j;
        sel = -1;
        for (int k = 1; k <= 16; k++) begin
            if (sel < 0 && k <= n) begin
                j = (rr + k) % n;
                if (eligible[j]) sel = j;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/cmult_arbiter_rr.sv
// Round-robin arbiter: combinational grant from eligible and the rr pointer,
// pointer moves to the granted index only when a transfer happens.
module rr_arbiter
    import dpd_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic [N_REQ-1:0] eligible,
    input  logic             transfer,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [ID_W-1:0] rr_q;
    int              sel;

    always_comb begin
        sel       = rr_next(16'(eligible), int'(rr_q), N_REQ);
        grant_any = (sel >= 0);
        grant_id  = grant_any ? ID_W'(sel) : '0;
        grant     = grant_any ? (N_REQ'(1) << grant_id) : '0;
    end

    // Reset pointer to the last index so requester 0 wins the first search.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rr_q <= ID_W'(N_REQ - 1);
        end else if (transfer) begin
            rr_q <= grant_id;
        end
    end

endmodule

// File: rtl/compl_mult.sv
// Complex multiply of Q1.(W-1) operands, rounded half-up back to W bits.
// Results wrap rather than saturate.
module compl_mult #(
    parameter int W = 20
) (
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic [2*W-1:0] p
);

    logic signed [W-1:0]   ai, aq, bi, bq;
    logic signed [2*W-1:0] pp_ii, pp_qq, pp_qi, pp_iq;
    logic signed [2*W:0]   sum_i, sum_q;
    logic [W-1:0]          res_i, res_q;

    assign ai = a[2*W-1:W];
    assign aq = a[W-1:0];
    assign bi = b[2*W-1:W];
    assign bq = b[W-1:0];

    assign pp_ii = (2*W)'(ai) * (2*W)'(bi);
    assign pp_qq = (2*W)'(aq) * (2*W)'(bq);
    assign pp_qi = (2*W)'(aq) * (2*W)'(bi);
    assign pp_iq = (2*W)'(ai) * (2*W)'(bq);

    assign sum_i = (2*W+1)'(pp_ii) - (2*W+1)'(pp_qq);
    assign sum_q = (2*W+1)'(pp_qi) + (2*W+1)'(pp_iq);

    // Keep bits [2W-2:W-1]; the bit just below the kept field is the rounding increment.
    assign res_i = sum_i[2*W-2:W-1] + {{(W-1){1'b0}}, sum_i[W-2]};
    assign res_q = sum_q[2*W-2:W-1] + {{(W-1){1'b0}}, sum_q[W-2]};

    assign p = {res_i, res_q};

endmodule

// File: rtl/cmult_arbiter.sv
// Shares one compl_mult between N_REQ valid/ready requesters through a
// round-robin grant and a 2-stage pipeline; products return tagged with rsp_id.
module cmult_arbiter
    import dpd_pkg::*;
#(
    parameter int W     = CPLX_W,
    parameter int N_REQ = 4,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [N_REQ-1:0]   cfg_mask,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*2*W-1:0] req_a,
    input  logic [N_REQ*2*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [2*W-1:0]     rsp_data
);

    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             grant_any;
    logic             adv1, adv2, transfer;
    logic [2*W-1:0]   sel_a, sel_b, prod;

    logic             s1_v, s2_v;
    logic [2*W-1:0]   s1_a, s1_b, s2_p;
    logic [ID_W-1:0]  s1_id, s2_id;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .clk       (clk),
        .reset_b   (reset_b),
        .eligible  (req_valid & cfg_mask),
        .transfer  (transfer),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    compl_mult #(.W(W)) u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    // Each stage moves when the one downstream has room, so a full pipe never bubbles.
    assign adv2      = ~s2_v | rsp_ready;
    assign adv1      = ~s1_v | adv2;
    assign transfer  = grant_any & adv1;
    assign req_ready = grant & {N_REQ{adv1}};

    assign sel_a = req_a[int'(grant_id)*(2*W) +: 2*W];
    assign sel_b = req_b[int'(grant_id)*(2*W) +: 2*W];

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
            s2_v  <= 1'b0;
            s2_p  <= '0;
            s2_id <= '0;
        end else begin
            if (adv1) begin
                s1_v <= transfer;
                if (transfer) begin
                    s1_a  <= sel_a;
                    s1_b  <= sel_b;
                    s1_id <= grant_id;
                end
            end
            if (adv2) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_p  <= prod;
                    s2_id <= s1_id;
                end
            end
        end
    end

    assign rsp_valid = s2_v;
    assign rsp_id    = s2_id;
    assign rsp_data  = s2_p;

endmodule
